cpu_top: RTL and testbench
==========================

CPU_TOP -- requirements
Module: cpu_top

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 The port clk SHALL be an input, 1 bit wide, and act as the system clock; all state updates occur on its rising edge.
REQ-003 The port rst_n SHALL be an input, 1 bit wide, and act as the asynchronous active-low reset.
REQ-004 The port i_mem_addr SHALL be an output, 32 bits wide, carrying the instruction fetch byte address (equal to the PC).
REQ-005 The port i_mem_rdata SHALL be an input, 32 bits wide, carrying the instruction word; memory returns it combinationally in the same cycle.
REQ-006 The port d_mem_addr SHALL be an output, 32 bits wide, carrying the data byte address (rs1 + imm) for loads and stores.
REQ-007 The port d_mem_wdata SHALL be an output, 32 bits wide, carrying store data with lanes replicated.
REQ-008 The port d_mem_wen SHALL be an output, 4 bits wide, carrying the byte-lane write enables; bit n enables byte n.
REQ-009 The port d_mem_rdata SHALL be an input, 32 bits wide, carrying combinational load data for the word containing d_mem_addr.
REQ-010 The module SHALL have no parameters.

Function
REQ-011 The core SHALL be a single-cycle RV32I processor: fetch, decode, execute, memory and writeback complete in one clk cycle, and each cycle retires one instruction.
REQ-012 The core SHALL support LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM instructions and all OP instructions (funct7 0000000/0100000).
REQ-013 The register file SHALL be 32x32; x0 reads 0 and writes to it are discarded; it has two combinational read ports and one write port updated at posedge.
REQ-014 Arithmetic SHALL be modulo 2^32 with no overflow trap; shifts use the low 5 bits of the shift amount; SRA/SRAI sign-extend.
REQ-015 The next PC SHALL be PC+4 by default, PC+imm for a taken branch or JAL, and (rs1+imm) with bit 0 cleared for JALR; JAL/JALR write PC+4 to rd; the redirect takes effect on the next fetch with no delay slot.
REQ-016 For SW, d_mem_wen SHALL be 1111; for SH, it SHALL be 0011 or 1100 selected by addr[1]; for SB, it SHALL be 0001<<addr[1:0]; and d_mem_wdata SHALL be the byte or halfword replicated across lanes.
REQ-017 Loads SHALL extract the byte or halfword from d_mem_rdata using addr[1:0] and then sign-extend (LB/LH) or zero-extend (LBU/LHU).
REQ-018 Misaligned addresses SHALL NOT trap; SH/LH use addr[1] only and SW/LW ignore addr[1:0].
REQ-019 d_mem_wen SHALL be 0000 for every non-store instruction.
REQ-020 Unknown or illegal opcodes (e.g. 0xDEADBEEF), FENCE, ECALL, EBREAK and SYSTEM instructions SHALL execute as NOPs: no register write, no store, PC+4.

Reset
REQ-021 While rst_n=0, the PC SHALL be 0x00000000, i_mem_addr SHALL be 0x00000000, d_mem_wen SHALL be 0000, and all registers x1..x31 SHALL be 0.
REQ-022 Reset assertion SHALL take effect immediately regardless of clk, and any in-flight instruction SHALL be discarded without a register or memory write.
REQ-023 At the first rising edge after rst_n rises, the instruction at address 0x0 SHALL retire.

Configuration
REQ-024 With the macro CPU_MUL_EN defined, OP instructions with funct7=0000001 and funct3=000 (MUL) SHALL write the low 32 bits of rs1*rs2 to rd.
REQ-025 Without CPU_MUL_EN, every funct7=0000001 OP instruction SHALL be a NOP per REQ-020.
REQ-026 Other RV32M operations (MULH, DIV, and the rest) SHALL be NOPs in both configurations.

Verification
REQ-027 The bench SHALL hold rst_n low for 5 cycles and check that i_mem_addr=0x0 and d_mem_wen=0000 throughout; after release, i_mem_addr SHALL read 0x0, 0x4, 0x8 on successive cycles.
REQ-028 The bench SHALL run ADDI x1,x0,5; ADDI x2,x0,7; ADD x3,x1,x2; SW x3,0x10(x0) and check a single write with d_mem_addr=0x10, d_mem_wdata=0x0000000C and d_mem_wen=1111.
REQ-029 The bench SHALL run LUI x1,0x80000; ADD x2,x1,x1; ADDI x3,x0,-1; SW x2,0(x0); SW x3,4(x0) and check that mem[0]=0x00000000 and mem[4]=0xFFFFFFFF.
REQ-030 The bench SHALL run ADDI x1,x0,0xAB; SB x1,0x101(x0); LB x2,0x101(x0); LBU x3,0x101(x0) and check wen=0010 with wdata=0xABABABAB, x2=0xFFFFFFAB and x3=0x000000AB.
REQ-031 The bench SHALL run BEQ x0,x0,+8 at 0x0 and then JAL x1,+8 at 0x8, and check a fetch at 0x8, a fetch at 0x10 and x1=0x0000000C.
REQ-032 The bench SHALL run ADDI x1,x0,6; ADDI x2,x0,7; MUL x3,x1,x2; SW x3,0(x0) and check mem[0]=42 with CPU_MUL_EN defined and mem[0]=0 without it.

Source files
------------

// File: rtl/cpu_top.sv
// cpu_top: single-cycle RV32I core. Each clk cycle fetches, executes and retires one
// instruction. Instruction and data memories are external and combinational.
//
// Ports
//   clk          system clock, all state updates on its rising edge
//   rst_n        asynchronous active-low reset
//   i_mem_addr   instruction fetch byte address (the PC)
//   i_mem_rdata  instruction word at i_mem_addr, same cycle
//   d_mem_addr   data byte address (rs1 + imm) for loads and stores
//   d_mem_wdata  store data, byte/halfword replicated across lanes
//   d_mem_wen    byte-lane write enables, bit n enables byte n
//   d_mem_rdata  load data for the word containing d_mem_addr, same cycle
//
// Configuration
//   CPU_MUL_EN   when defined, OP funct7=0000001 funct3=000 (MUL) writes the low 32 bits of
//                rs1*rs2. All other RV32M encodings are NOPs in either build.
//
// Unknown opcodes, FENCE and SYSTEM encodings retire as NOPs (no write, PC+4).

module cpu_top (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] i_mem_addr,
   input  logic [31:0] i_mem_rdata,
   output logic [31:0] d_mem_addr,
   output logic [31:0] d_mem_wdata,
   output logic [3:0]  d_mem_wen,
   input  logic [31:0] d_mem_rdata
);

   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpReg    = 7'b0110011;

   logic [31:0] r_pc;
   logic [31:0] r_regs [0:31];

   logic [6:0]  w_opcode;
   logic [4:0]  w_rd, w_rs1, w_rs2;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
   logic [31:0] w_a, w_b, w_alu_b, w_alu;
   logic [31:0] w_mul;
   logic        w_is_mul;
   logic        w_alt;
   logic        w_op_legal, w_imm_legal;
   logic        w_br_taken;
   logic [31:0] w_pc_plus4, w_pc_next;
   logic [31:0] w_addr;
   logic [7:0]  w_ld_byte;
   logic [15:0] w_ld_half;
   logic        w_we;
   logic [31:0] w_wd;
   logic [3:0]  w_wen_raw;
   logic [31:0] w_wdata;

   // ---------------- decode ----------------
   assign w_opcode = i_mem_rdata[6:0];
   assign w_rd     = i_mem_rdata[11:7];
   assign w_f3     = i_mem_rdata[14:12];
   assign w_rs1    = i_mem_rdata[19:15];
   assign w_rs2    = i_mem_rdata[24:20];
   assign w_f7     = i_mem_rdata[31:25];

   assign w_imm_i = {{20{i_mem_rdata[31]}}, i_mem_rdata[31:20]};
   assign w_imm_s = {{20{i_mem_rdata[31]}}, i_mem_rdata[31:25], i_mem_rdata[11:7]};
   assign w_imm_b = {{19{i_mem_rdata[31]}}, i_mem_rdata[31], i_mem_rdata[7],
                     i_mem_rdata[30:25], i_mem_rdata[11:8], 1'b0};
   assign w_imm_u = {i_mem_rdata[31:12], 12'b0};
   assign w_imm_j = {{11{i_mem_rdata[31]}}, i_mem_rdata[31], i_mem_rdata[19:12],
                     i_mem_rdata[20], i_mem_rdata[30:21], 1'b0};

   assign w_a = (w_rs1 == 5'd0) ? 32'b0 : r_regs[w_rs1];
   assign w_b = (w_rs2 == 5'd0) ? 32'b0 : r_regs[w_rs2];

   assign w_pc_plus4 = r_pc + 32'd4;
   assign i_mem_addr = r_pc;

`ifdef CPU_MUL_EN
   assign w_is_mul = (w_opcode == OpReg) && (w_f7 == 7'b0000001) && (w_f3 == 3'b000);
   assign w_mul    = w_a * w_b;
`else
   assign w_is_mul = 1'b0;
   assign w_mul    = 32'b0;
`endif

   // funct7 0100000 is only meaningful for SUB/SRA (OP) and SRAI (OP-IMM)
   assign w_op_legal = (w_f7 == 7'b0000000)
                    || ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)))
                    || w_is_mul;
   assign w_imm_legal = (w_f3 == 3'b001) ? (w_f7 == 7'b0000000) :
                        (w_f3 == 3'b101) ? ((w_f7 == 7'b0000000) || (w_f7 == 7'b0100000)) :
                        1'b1;

   // ---------------- ALU (shared by OP and OP-IMM) ----------------
   assign w_alu_b = (w_opcode == OpReg) ? w_b : w_imm_i;
   // ADDI has no SUB form, so bit 30 selects the alternate op only for OP or shifts
   assign w_alt   = w_f7[5] && ((w_opcode == OpReg) || (w_f3 == 3'b101));

   always_comb begin
      w_alu = 32'b0;
      case (w_f3)
         3'b000:  w_alu = w_alt ? (w_a - w_alu_b) : (w_a + w_alu_b);
         3'b001:  w_alu = w_a << w_alu_b[4:0];
         3'b010:  w_alu = {31'b0, $signed(w_a) < $signed(w_alu_b)};
         3'b011:  w_alu = {31'b0, w_a < w_alu_b};
         3'b100:  w_alu = w_a ^ w_alu_b;
         3'b101:  w_alu = w_alt ? $unsigned($signed(w_a) >>> w_alu_b[4:0])
                                : (w_a >> w_alu_b[4:0]);
         3'b110:  w_alu = w_a | w_alu_b;
         default: w_alu = w_a & w_alu_b;
      endcase
   end

   always_comb begin
      w_br_taken = 1'b0;
      case (w_f3)
         3'b000:  w_br_taken = (w_a == w_b);
         3'b001:  w_br_taken = (w_a != w_b);
         3'b100:  w_br_taken = $signed(w_a) <  $signed(w_b);
         3'b101:  w_br_taken = $signed(w_a) >= $signed(w_b);
         3'b110:  w_br_taken = w_a <  w_b;
         3'b111:  w_br_taken = w_a >= w_b;
         default: w_br_taken = 1'b0;
      endcase
   end

   // ---------------- memory ----------------
   assign w_addr     = (w_opcode == OpStore) ? (w_a + w_imm_s) : (w_a + w_imm_i);
   assign d_mem_addr = w_addr;
   assign w_ld_byte  = d_mem_rdata[{w_addr[1:0], 3'b000} +: 8];
   assign w_ld_half  = w_addr[1] ? d_mem_rdata[31:16] : d_mem_rdata[15:0];

   // ---------------- execute / writeback select ----------------
   always_comb begin
      w_we      = 1'b0;
      w_wd      = 32'b0;
      w_pc_next = w_pc_plus4;
      w_wen_raw = 4'b0000;
      w_wdata   = w_b;
      case (w_opcode)
         OpLui: begin
            w_we = 1'b1;
            w_wd = w_imm_u;
         end
         OpAuipc: begin
            w_we = 1'b1;
            w_wd = r_pc + w_imm_u;
         end
         OpJal: begin
            w_we      = 1'b1;
            w_wd      = w_pc_plus4;
            w_pc_next = r_pc + w_imm_j;
         end
         OpJalr: begin
            if (w_f3 == 3'b000) begin
               w_we      = 1'b1;
               w_wd      = w_pc_plus4;
               w_pc_next = (w_a + w_imm_i) & 32'hFFFF_FFFE;
            end
         end
         OpBranch: begin
            if (w_br_taken) w_pc_next = r_pc + w_imm_b;
         end
         OpLoad: begin
            case (w_f3)
               3'b000: begin w_we = 1'b1; w_wd = {{24{w_ld_byte[7]}}, w_ld_byte};  end
               3'b001: begin w_we = 1'b1; w_wd = {{16{w_ld_half[15]}}, w_ld_half}; end
               3'b010: begin w_we = 1'b1; w_wd = d_mem_rdata;                      end
               3'b100: begin w_we = 1'b1; w_wd = {24'b0, w_ld_byte};               end
               3'b101: begin w_we = 1'b1; w_wd = {16'b0, w_ld_half};               end
               default: ;
            endcase
         end
         OpStore: begin
            case (w_f3)
               3'b000: begin
                  w_wen_raw = 4'b0001 << w_addr[1:0];
                  w_wdata   = {4{w_b[7:0]}};
               end
               3'b001: begin
                  w_wen_raw = w_addr[1] ? 4'b1100 : 4'b0011;
                  w_wdata   = {2{w_b[15:0]}};
               end
               3'b010:  w_wen_raw = 4'b1111;
               default: ;
            endcase
         end
         OpImm: begin
            if (w_imm_legal) begin
               w_we = 1'b1;
               w_wd = w_alu;
            end
         end
         OpReg: begin
            if (w_op_legal) begin
               w_we = 1'b1;
               w_wd = w_is_mul ? w_mul : w_alu;
            end
         end
         default: ;
      endcase
   end

   assign d_mem_wdata = w_wdata;
   // reset must suppress the store of whatever instruction sits at the PC
   assign d_mem_wen   = w_wen_raw & {4{rst_n}};

   // ---------------- state ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= 32'b0;
      end else begin
         r_pc <= w_pc_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= 32'b0;
      end else if (w_we && (w_rd != 5'd0)) begin
         r_regs[w_rd] <= w_wd;
      end
   end

endmodule

// File: tb/tb_cpu_top.sv
// Directed bench for cpu_top: small hand-encoded programs, combinational instruction/data
// memories, and a log of every store the core issues.

module tb_cpu_top;

   logic        clk;
   logic        rst_n;
   logic [31:0] i_mem_addr, i_mem_rdata;
   logic [31:0] d_mem_addr, d_mem_wdata, d_mem_rdata;
   logic [3:0]  d_mem_wen;

   logic [31:0] imem [0:255];
   logic [31:0] dmem [0:255];
   logic        clr_req;

   logic [31:0] log_a [0:15];
   logic [31:0] log_d [0:15];
   logic [3:0]  log_w [0:15];
   logic [4:0]  n_wr;

   int n_vec;
   int n_bad;

   localparam logic [31:0] Nop = 32'h0000_0013;

   cpu_top u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_mem_addr  (i_mem_addr),
      .i_mem_rdata (i_mem_rdata),
      .d_mem_addr  (d_mem_addr),
      .d_mem_wdata (d_mem_wdata),
      .d_mem_wen   (d_mem_wen),
      .d_mem_rdata (d_mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign i_mem_rdata = imem[i_mem_addr[9:2]];
   assign d_mem_rdata = dmem[d_mem_addr[9:2]];

   always @(posedge clk) begin
      if (clr_req) begin
         for (int i = 0; i < 256; i++) dmem[i] <= 32'b0;
         n_wr <= 5'd0;
      end else if (rst_n && (d_mem_wen != 4'b0000)) begin
         for (int b = 0; b < 4; b++)
            if (d_mem_wen[b]) dmem[d_mem_addr[9:2]][8*b +: 8] <= d_mem_wdata[8*b +: 8];
         if (n_wr < 5'd16) begin
            log_a[n_wr[3:0]] <= d_mem_addr;
            log_d[n_wr[3:0]] <= d_mem_wdata;
            log_w[n_wr[3:0]] <= d_mem_wen;
         end
         n_wr <= n_wr + 5'd1;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- instruction encoders ----------------
   function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm[11:0], rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [31:0] imm);
      return enc_i(imm, rs1, 3'b000, rd, 7'h13);
   endfunction

   function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [31:0] imm);
      return enc_s(imm, rs2, 5'd0, 3'b010);
   endfunction

   // ---------------- sequencing ----------------
   task automatic reset_begin();
      @(negedge clk);
      rst_n   = 1'b0;
      clr_req = 1'b1;
      for (int i = 0; i < 256; i++) imem[i] = Nop;
   endtask

   task automatic reset_end();
      @(negedge clk);
      clr_req = 1'b0;
      rst_n   = 1'b1;
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      n_vec   = 0;
      n_bad   = 0;
      rst_n   = 1'b0;
      clr_req = 1'b1;

      // ---- reset behaviour: every word is a store, so any leak shows on d_mem_wen ----
      for (int i = 0; i < 256; i++) imem[i] = sw(5'd0, 32'h0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check_val("rst_pc", i_mem_addr, 32'h0);
         check_val("rst_wen", {28'b0, d_mem_wen}, 32'h0);
      end
      clr_req = 1'b0;
      rst_n   = 1'b1;
      #1;
      check_val("fetch0", i_mem_addr, 32'h0);
      check_val("fetch0_wen", {28'b0, d_mem_wen}, 32'hF);
      @(negedge clk);
      check_val("fetch1", i_mem_addr, 32'h4);
      @(negedge clk);
      check_val("fetch2", i_mem_addr, 32'h8);

      // ---- ADDI/ADD/SW, then ECALL as a NOP ----
      reset_begin();
      imem[0] = addi(5'd1, 5'd0, 32'd5);
      imem[1] = addi(5'd2, 5'd0, 32'd7);
      imem[2] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3);
      imem[3] = sw(5'd3, 32'h10);
      imem[4] = 32'h0000_0073;
      reset_end();
      run(5);
      check_val("add_pc_after_ecall", i_mem_addr, 32'h14);
      check_val("add_nwr", {27'b0, n_wr}, 32'd1);
      check_val("add_addr", log_a[0], 32'h10);
      check_val("add_wdata", log_d[0], 32'h0000_000C);
      check_val("add_wen", {28'b0, log_w[0]}, 32'hF);

      // ---- wrap-around ADD and all-ones ----
      reset_begin();
      imem[0] = {20'h80000, 5'd1, 7'h37};
      imem[1] = enc_r(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd2);
      imem[2] = addi(5'd3, 5'd0, 32'hFFFF_FFFF);
      imem[3] = sw(5'd2, 32'h0);
      imem[4] = sw(5'd3, 32'h4);
      reset_end();
      run(6);
      check_val("wrap_nwr", {27'b0, n_wr}, 32'd2);
      check_val("wrap_log0", log_d[0], 32'h0);
      check_val("wrap_mem0", dmem[0], 32'h0);
      check_val("wrap_mem4", dmem[1], 32'hFFFF_FFFF);

      // ---- sub-word stores, loads with sign/zero extension, SRAI ----
      reset_begin();
      imem[0]  = addi(5'd1, 5'd0, 32'hAB);
      imem[1]  = enc_s(32'h101, 5'd1, 5'd0, 3'b000);
      imem[2]  = enc_i(32'h101, 5'd0, 3'b000, 5'd2, 7'h03);
      imem[3]  = enc_i(32'h101, 5'd0, 3'b100, 5'd3, 7'h03);
      imem[4]  = sw(5'd2, 32'h20);
      imem[5]  = sw(5'd3, 32'h24);
      imem[6]  = addi(5'd4, 5'd0, 32'hFFFF_FFFE);
      imem[7]  = enc_s(32'h32, 5'd4, 5'd0, 3'b001);
      imem[8]  = enc_i(32'h32, 5'd0, 3'b101, 5'd5, 7'h03);
      imem[9]  = enc_i(32'h32, 5'd0, 3'b001, 5'd6, 7'h03);
      imem[10] = sw(5'd5, 32'h28);
      imem[11] = sw(5'd6, 32'h2C);
      imem[12] = addi(5'd7, 5'd0, 32'hFFFF_FFF0);
      imem[13] = enc_i(32'h402, 5'd7, 3'b101, 5'd8, 7'h13);
      imem[14] = sw(5'd8, 32'h34);
      reset_end();
      run(17);
      check_val("sb_addr", log_a[0], 32'h101);
      check_val("sb_wen", {28'b0, log_w[0]}, 32'h2);
      check_val("sb_wdata", log_d[0], 32'hABAB_ABAB);
      check_val("sb_mem", dmem[64], 32'h0000_AB00);
      check_val("lb_x2", log_d[1], 32'hFFFF_FFAB);
      check_val("lbu_x3", log_d[2], 32'h0000_00AB);
      check_val("sh_wen", {28'b0, log_w[3]}, 32'hC);
      check_val("sh_wdata", log_d[3], 32'hFFFE_FFFE);
      check_val("sh_mem", dmem[12], 32'hFFFE_0000);
      check_val("lhu_x5", log_d[4], 32'h0000_FFFE);
      check_val("lh_x6", log_d[5], 32'hFFFF_FFFE);
      check_val("srai_x8", log_d[6], 32'hFFFF_FFFC);
      check_val("sub_nwr", {27'b0, n_wr}, 32'd7);

      // ---- BEQ taken, JAL link, JALR with bit 0 cleared, async reset mid-run ----
      reset_begin();
      imem[0]  = enc_b(32'd8, 5'd0, 5'd0, 3'b000);
      imem[1]  = sw(5'd0, 32'h60);
      imem[2]  = enc_j(32'd8, 5'd1);
      imem[3]  = sw(5'd0, 32'h64);
      imem[4]  = sw(5'd1, 32'h50);
      imem[5]  = enc_i(32'h21, 5'd1, 3'b000, 5'd0, 7'h67);
      imem[11] = sw(5'd1, 32'h54);
      reset_end();
      #1;
      check_val("br_fetch0", i_mem_addr, 32'h0);
      @(negedge clk);
      check_val("br_fetch1", i_mem_addr, 32'h8);
      @(negedge clk);
      check_val("jal_fetch", i_mem_addr, 32'h10);
      @(negedge clk);
      check_val("jal_fetch_next", i_mem_addr, 32'h14);
      @(negedge clk);
      check_val("jalr_fetch", i_mem_addr, 32'h2C);
      @(negedge clk);
      check_val("jal_link", log_d[0], 32'h0000_000C);
      check_val("jal_link_addr", log_a[0], 32'h50);
      check_val("jalr_store_addr", log_a[1], 32'h54);
      check_val("br_nwr", {27'b0, n_wr}, 32'd2);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_rst_pc", i_mem_addr, 32'h0);
      check_val("async_rst_wen", {28'b0, d_mem_wen}, 32'h0);

      // ---- MUL (config dependent) and DIV (always NOP) ----
      reset_begin();
      imem[0] = addi(5'd1, 5'd0, 32'd6);
      imem[1] = addi(5'd2, 5'd0, 32'd7);
      imem[2] = enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3);
      imem[3] = sw(5'd3, 32'h0);
      imem[4] = enc_r(7'b0000001, 5'd2, 5'd1, 3'b100, 5'd4);
      imem[5] = sw(5'd4, 32'h4);
      reset_end();
      run(7);
`ifdef CPU_MUL_EN
      check_val("mul_result", dmem[0], 32'd42);
`else
      check_val("mul_result", dmem[0], 32'd0);
`endif
      check_val("div_nop", dmem[1], 32'd0);
      check_val("mul_nwr", {27'b0, n_wr}, 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
